// File: rtl/comb_addsub_seq.sv
// ----------------------------------------------------------------------------
// comb_addsub_seq
//   Time-multiplexed CIC comb (differentiator) sequencer. A single external
//   registered 16-bit add/sub unit computes every comb stage of every channel:
//   y = x - x[n-1], repeated NUM_STAGES times per channel, once per input
//   strobe. Arithmetic is two's complement and wraps modulo 2^16.
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   enable           0 = hold idle, clear all state (synchronous)
//   strobe_in        one-cycle pulse, signal_in valid
//   signal_in        packed samples, ch0 in [15:0]
//   signal_out       comb outputs, same packing, held between strobes
//   strobe_out       one-cycle pulse, signal_out valid
//   overrun          one-cycle pulse, strobe_in dropped while busy
//   addsub_add_sub   to adder, tied to subtract (0)
//   addsub_dataa/b   to adder, registered minuend / subtrahend
//   addsub_result    from adder, registered one clock after its operands
// ----------------------------------------------------------------------------
module comb_addsub_seq #(
    parameter int NUM_CHAN   = 2,
    parameter int NUM_STAGES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   strobe_in,
    input  logic [16*NUM_CHAN-1:0] signal_in,
    output logic [16*NUM_CHAN-1:0] signal_out,
    output logic                   strobe_out,
    output logic                   overrun,
    output logic                   addsub_add_sub,
    output logic [15:0]            addsub_dataa,
    output logic [15:0]            addsub_datab,
    input  logic [15:0]            addsub_result
);

    localparam int CW = (NUM_CHAN   > 1) ? $clog2(NUM_CHAN)   : 1;
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CW-1:0] LAST_CHAN  = CW'(NUM_CHAN - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                                state_q,   state_d;
    logic [CW-1:0]                         chan_q,    chan_d;
    logic [SW-1:0]                         stage_q,   stage_d;
    logic [NUM_CHAN-1:0][15:0]             work_q,    work_d;
    logic [NUM_CHAN-1:0][15:0]             sig_out_q, sig_out_d;
    logic [NUM_CHAN-1:0][NUM_STAGES-1:0][15:0] delay_q, delay_d;
    logic [15:0]                           dataa_q,   dataa_d;
    logic [15:0]                           datab_q,   datab_d;

    logic [NUM_CHAN-1:0][15:0] samp_in;
    logic [CW-1:0]             nxt_chan;
    logic [SW-1:0]             nxt_stage;
    logic [15:0]               nxt_a;

    assign samp_in = signal_in;

    // Operands for each step are loaded on the edge that enters ISSUE, so they
    // are stable throughout ISSUE; the adder registers them at the end of
    // ISSUE and its result is taken at the end of WAIT. The delay tap is
    // rewritten with the new stage input in the same edge its old value is
    // read as the subtrahend.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        stage_d   = stage_q;
        work_d    = work_q;
        sig_out_d = sig_out_q;
        delay_d   = delay_q;
        dataa_d   = dataa_q;
        datab_d   = datab_q;
        nxt_chan  = chan_q;
        nxt_stage = stage_q;
        nxt_a     = addsub_result;

        case (state_q)
            IDLE: begin
                if (strobe_in) begin
                    work_d        = samp_in;
                    chan_d        = '0;
                    stage_d       = '0;
                    dataa_d       = samp_in[0];
                    datab_d       = delay_q[0][0];
                    delay_d[0][0] = samp_in[0];
                    state_d       = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                work_d[chan_q] = addsub_result;
                if (stage_q != LAST_STAGE) begin
                    nxt_stage = stage_q + SW'(1);
                    nxt_a     = addsub_result;
                end else begin
                    nxt_chan  = chan_q + CW'(1);
                    nxt_stage = '0;
                    nxt_a     = work_q[nxt_chan];
                end
                if (stage_q == LAST_STAGE && chan_q == LAST_CHAN) begin
                    sig_out_d = work_d;
                    state_d   = DONE;
                end else begin
                    chan_d                       = nxt_chan;
                    stage_d                      = nxt_stage;
                    dataa_d                      = nxt_a;
                    datab_d                      = delay_q[nxt_chan][nxt_stage];
                    delay_d[nxt_chan][nxt_stage] = nxt_a;
                    state_d                      = ISSUE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            stage_q   <= '0;
            work_q    <= '0;
            sig_out_q <= '0;
            delay_q   <= '0;
            dataa_q   <= '0;
            datab_q   <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            stage_q   <= stage_d;
            work_q    <= work_d;
            sig_out_q <= sig_out_d;
            delay_q   <= delay_d;
            dataa_q   <= dataa_d;
            datab_q   <= datab_d;
        end
    end

    // Pulses are gated so an abort cycle never shows a strobe or overrun.
    assign strobe_out     = (state_q == DONE) && !reset && enable;
    assign overrun        = strobe_in && (state_q != IDLE) && !reset && enable;
    assign signal_out     = sig_out_q;
    assign addsub_add_sub = 1'b0;
    assign addsub_dataa   = dataa_q;
    assign addsub_datab   = datab_q;

endmodule

// File: tb/tb_comb_addsub_seq.sv
module tb_comb_addsub_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        strobe_in = 1'b0;
    logic [31:0] signal_in = '0;
    logic [31:0] signal_out;
    logic        strobe_out, overrun, addsub_add_sub;
    logic [15:0] addsub_dataa, addsub_datab, addsub_result;

    int checks = 0;
    int errors = 0;
    logic add_seen = 1'b0;

    comb_addsub_seq #(.NUM_CHAN(2), .NUM_STAGES(4)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .strobe_in(strobe_in), .signal_in(signal_in),
        .signal_out(signal_out), .strobe_out(strobe_out), .overrun(overrun),
        .addsub_add_sub(addsub_add_sub), .addsub_dataa(addsub_dataa),
        .addsub_datab(addsub_datab), .addsub_result(addsub_result)
    );

    always #5 clock = ~clock;

    // registered add/sub unit model
    always @(posedge clock)
        addsub_result <= addsub_add_sub ? addsub_dataa + addsub_datab
                                        : addsub_dataa - addsub_datab;

    always @(negedge clock)
        if (addsub_add_sub !== 1'b0) add_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One sample. Cycle 0 carries strobe_in; cycles are counted at negedges.
    // ovr_at: cycle with a second (dropped) strobe; abort_at: cycle with
    // reset (abort_en=0) or enable low (abort_en=1). lat=-1 if no strobe_out.
    task automatic run(input logic [15:0] s0, input logic [15:0] s1,
                       input int ovr_at, input int abort_at, input bit abort_en,
                       output logic [15:0] o0, output logic [15:0] o1, output int lat);
        lat = -1;
        o0  = '0;
        o1  = '0;
        @(negedge clock);
        signal_in = {s1, s0};
        strobe_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            strobe_in = (k == ovr_at);
            signal_in = (k == ovr_at) ? 32'h5A5A_A5A5 : 32'h0;
            reset     = (k == abort_at) && !abort_en;
            enable    = !((k == abort_at) && abort_en);
            #1;
            if (k == ovr_at) chk("overrun_pulse", {31'b0, overrun}, 32'd1);
            if (strobe_out) begin
                lat = k;
                o0  = signal_out[15:0];
                o1  = signal_out[31:16];
                break;
            end
        end
        strobe_in = 1'b0;
        reset     = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    logic [15:0] o0, o1;
    int          lat;
    logic [15:0] imp_exp [6] = '{16'h0001, 16'hFFFC, 16'h0006, 16'hFFFC, 16'h0001, 16'h0000};
    logic [15:0] dc_exp  [6] = '{16'h0064, 16'hFED4, 16'h012C, 16'hFF9C, 16'h0000, 16'h0000};
    logic [15:0] wr_in   [3] = '{16'h8000, 16'h7FFF, 16'h0000};
    logic [15:0] wr_exp  [3] = '{16'h8000, 16'h7FFF, 16'h0004};

    initial begin
        // reset state, strobe_in ignored while in reset
        repeat (2) @(negedge clock);
        strobe_in = 1'b1;
        #1;
        chk("rst_strobe_out", {31'b0, strobe_out}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_signal_out", signal_out, 32'd0);
        chk("rst_operands", {addsub_dataa, addsub_datab}, 32'd0);
        @(negedge clock);
        strobe_in = 1'b0;
        reset = 1'b0;

        // impulse on ch0; also latency and back-to-back acceptance
        for (int i = 0; i < 6; i++) begin
            run((i == 0) ? 16'd1 : 16'd0, 16'd0, 0, 0, 1'b0, o0, o1, lat);
            chk($sformatf("imp_ch0_%0d", i), {16'b0, o0}, {16'b0, imp_exp[i]});
            chk($sformatf("imp_ch1_%0d", i), {16'b0, o1}, 32'd0);
            if (i < 2) chk($sformatf("imp_lat_%0d", i), lat, 32'd17);
        end

        // DC on ch1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run(16'd0, 16'd100, 0, 0, 1'b0, o0, o1, lat);
            chk($sformatf("dc_ch1_%0d", i), {16'b0, o1}, {16'b0, dc_exp[i]});
            chk($sformatf("dc_ch0_%0d", i), {16'b0, o0}, 32'd0);
        end

        // wrap-around
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run(wr_in[i], 16'd0, 0, 0, 1'b0, o0, o1, lat);
            chk($sformatf("wrap_ch0_%0d", i), {16'b0, o0}, {16'b0, wr_exp[i]});
        end

        // dropped strobe at cycle 5: overrun, sequence unaffected
        do_reset();
        run(16'd1, 16'd0, 5, 0, 1'b0, o0, o1, lat);
        chk("ovr_lat", lat, 32'd17);
        chk("ovr_out0", {o1, o0}, 32'h0000_0001);
        run(16'd0, 16'd0, 0, 0, 1'b0, o0, o1, lat);
        chk("ovr_out1", {o1, o0}, 32'h0000_FFFC);

        // abort by reset, then by enable; delays must be cleared
        for (int a = 0; a < 2; a++) begin
            do_reset();
            run(16'd7, 16'd9, 0, 8, a[0], o0, o1, lat);
            chk($sformatf("abort%0d_nostrobe", a), lat, 32'hFFFF_FFFF);
            for (int i = 0; i < 5; i++) begin
                run((i == 0) ? 16'd1 : 16'd0, 16'd0, 0, 0, 1'b0, o0, o1, lat);
                chk($sformatf("abort%0d_imp_%0d", a, i), {o1, o0}, {16'b0, imp_exp[i]});
            end
        end

        chk("add_sub_zero", {31'b0, add_seen}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
